// File: rtl/game_pkg.sv
// Shared constants, state types and the paddle clamp helper for the game controller.
package game_pkg;

  localparam int unsigned Y_W            = 11;
  localparam int unsigned Y_MIN          = 30;
  localparam int unsigned Y_MAX          = 450;
  localparam int unsigned Y_CENTER       = 240;
  localparam int unsigned BAT_HALF_LARGE = 29;
  localparam int unsigned BAT_HALF_SMALL = 19;
  localparam int unsigned STEP_SLOW      = 1;
  localparam int unsigned STEP_FAST      = 3;

  typedef enum logic [1:0] {
    IDLE,
    SLOW,
    FAST
  } paddle_state_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN
  } dir_t;

  // Saturate a signed candidate position into [lo, hi].
  function automatic logic [Y_W-1:0] clamp_y(input logic signed [Y_W:0] v,
                                             input logic [Y_W-1:0]      lo,
                                             input logic [Y_W-1:0]      hi);
    logic [Y_W-1:0] r;
    if (v < $signed({1'b0, lo})) begin
      r = lo;
    end else if (v > $signed({1'b0, hi})) begin
      r = hi;
    end else begin
      r = v[Y_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/paddle_axis.sv
// One paddle channel: button sync + debounce, accelerating move FSM, clamped position.
module paddle_axis
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned ACCEL_TICKS     = 24
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           up_i,
  input  logic           down_i,
  input  logic           tick_i,
  input  logic           center_i,
  input  logic [Y_W-1:0] lo_i,
  input  logic [Y_W-1:0] hi_i,
  output logic [Y_W-1:0] y_o,
  output logic           moving_o
);

  localparam int unsigned   CW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned   HW        = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(ACCEL_TICKS - 1);

  // Bit 0 = up button, bit 1 = down button.
  logic [1:0]           sync1_q;
  logic [1:0]           sync2_q;
  logic [1:0]           acc_q;
  logic [CW-1:0]        cnt_q [2];

  dir_t                 dir;
  paddle_state_t        state_q, state_d;
  dir_t                 dir_q, dir_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [Y_W-1:0]       y_q, y_d;
  logic                 moving_q, moving_d;
  logic signed [Y_W:0]  delta;
  logic signed [Y_W:0]  y_sum;

  // Two-flop synchronizers and per-button debounce counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      acc_q   <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= {down_i, up_i};
      sync2_q <= sync1_q;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2_q[i] == acc_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          acc_q[i] <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Direction from accepted button levels; both or neither means no movement.
  always_comb begin
    dir = DIR_NONE;
    if (acc_q == 2'b01) begin
      dir = DIR_UP;
    end else if (acc_q == 2'b10) begin
      dir = DIR_DOWN;
    end
  end

  // Next state, hold count and clamped position; recentre overrides any tick.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    hold_d  = hold_q;
    delta   = '0;
    if (center_i) begin
      state_d = IDLE;
      dir_d   = DIR_NONE;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (dir != DIR_NONE) begin
            state_d = SLOW;
            dir_d   = dir;
            hold_d  = '0;
          end
        end
        SLOW, FAST: begin
          if (dir == DIR_NONE) begin
            state_d = IDLE;
            dir_d   = DIR_NONE;
            hold_d  = '0;
          end else if (dir != dir_q) begin
            state_d = SLOW;
            dir_d   = dir;
            hold_d  = '0;
          end else if (tick_i) begin
            delta = (state_q == FAST) ? (Y_W+1)'(STEP_FAST) : (Y_W+1)'(STEP_SLOW);
            if (dir == DIR_UP) begin
              delta = -delta;
            end
            if (state_q == SLOW) begin
              if (hold_q == HOLD_LAST) begin
                state_d = FAST;
                hold_d  = '0;
              end else begin
                hold_d = hold_q + HW'(1);
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
          dir_d   = DIR_NONE;
          hold_d  = '0;
        end
      endcase
    end
    // Clamp runs every cycle so a limit change takes effect without a tick.
    if (center_i) begin
      y_sum = (Y_W+1)'(Y_CENTER);
    end else begin
      y_sum = $signed({1'b0, y_q}) + delta;
    end
    y_d      = clamp_y(y_sum, lo_i, hi_i);
    moving_d = (state_d != IDLE);
  end

  // Channel FSM with registered position and moving flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      dir_q    <= DIR_NONE;
      hold_q   <= '0;
      y_q      <= Y_W'(Y_CENTER);
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      hold_q   <= hold_d;
      y_q      <= y_d;
      moving_q <= moving_d;
    end
  end

  assign y_o      = y_q;
  assign moving_o = moving_q;

endmodule

// File: rtl/paddle_input_controller.sv
// Two-player paddle input front end: shared movement tick and bat-size limits.
module paddle_input_controller
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned TICK_DIV        = 65536,
  parameter int unsigned ACCEL_TICKS     = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p1_up,
  input  logic        p1_down,
  input  logic        p2_up,
  input  logic        p2_down,
  input  logic        bat_size,
  input  logic        center,
  output logic [10:0] p1_y,
  output logic [10:0] p2_y,
  output logic        p1_moving,
  output logic        p2_moving
);

  localparam int unsigned   PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]  pre_q;
  logic           tick;
  logic [Y_W-1:0] lo;
  logic [Y_W-1:0] hi;

  // Movement prescaler, wraps every TICK_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else if (pre_q == PRE_LAST) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PW'(1);
    end
  end

  assign tick = (pre_q == PRE_LAST);

  // Playfield limits for the active bat size.
  always_comb begin
    if (bat_size) begin
      lo = Y_W'(Y_MIN + BAT_HALF_SMALL);
      hi = Y_W'(Y_MAX - BAT_HALF_SMALL);
    end else begin
      lo = Y_W'(Y_MIN + BAT_HALF_LARGE);
      hi = Y_W'(Y_MAX - BAT_HALF_LARGE);
    end
  end

  paddle_axis #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACCEL_TICKS    (ACCEL_TICKS)
  ) u_p1 (
    .clk_i   (clk),
    .rst_i   (rst),
    .up_i    (p1_up),
    .down_i  (p1_down),
    .tick_i  (tick),
    .center_i(center),
    .lo_i    (lo),
    .hi_i    (hi),
    .y_o     (p1_y),
    .moving_o(p1_moving)
  );

  paddle_axis #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACCEL_TICKS    (ACCEL_TICKS)
  ) u_p2 (
    .clk_i   (clk),
    .rst_i   (rst),
    .up_i    (p2_up),
    .down_i  (p2_down),
    .tick_i  (tick),
    .center_i(center),
    .lo_i    (lo),
    .hi_i    (hi),
    .y_o     (p2_y),
    .moving_o(p2_moving)
  );

endmodule

// File: tb/tb_paddle_input_controller.sv
// Bench for paddle_input_controller: directed scenarios plus random buttons, checked every cycle.
module tb_paddle_input_controller;

  localparam int unsigned DB = 4;
  localparam int unsigned TD = 8;
  localparam int unsigned AT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
  logic        bat_size = 1'b0;
  logic        center = 1'b0;
  logic [10:0] p1_y, p2_y;
  logic        p1_moving, p2_moving;

  int n_assert = 0;
  int n_fail   = 0;

  paddle_input_controller #(
    .DEBOUNCE_CYCLES(DB),
    .TICK_DIV       (TD),
    .ACCEL_TICKS    (AT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .p1_up    (p1_up),
    .p1_down  (p1_down),
    .p2_up    (p2_up),
    .p2_down  (p2_down),
    .bat_size (bat_size),
    .center   (center),
    .p1_y     (p1_y),
    .p2_y     (p2_y),
    .p1_moving(p1_moving),
    .p2_moving(p2_moving)
  );

  always #5 clk = ~clk;

  // Reference model: edge count since reset, raw-sample delay line,
  // streak of accepted-vs-sample disagreement, and per-paddle motion.
  int m_e;
  bit m_s1 [4];
  bit m_s2 [4];
  bit m_acc [4];
  int m_streak [4];
  int m_y [2];
  bit m_act [2];
  int m_held [2];
  int m_dir [2];

  task automatic model_reset();
    m_e = 0;
    for (int b = 0; b < 4; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_acc[b] = 0; m_streak[b] = 0;
    end
    for (int c = 0; c < 2; c++) begin
      m_y[c] = 240; m_act[c] = 0; m_held[c] = 0; m_dir[c] = 0;
    end
  endtask

  task automatic model_update();
    bit raw [4];
    bit tk;
    int half, lo, hi, dir, step;
    raw[0] = p1_up; raw[1] = p1_down; raw[2] = p2_up; raw[3] = p2_down;
    if (rst) begin
      model_reset();
      return;
    end
    tk = ((m_e % TD) == TD - 1);
    m_e++;
    half = bat_size ? 19 : 29;
    lo = 30 + half;
    hi = 450 - half;
    for (int c = 0; c < 2; c++) begin
      dir = 0;
      if (m_acc[2*c] && !m_acc[2*c+1]) dir = -1;
      if (!m_acc[2*c] && m_acc[2*c+1]) dir = 1;
      if (center) begin
        m_y[c] = 240; m_act[c] = 0; m_held[c] = 0; m_dir[c] = 0;
      end else if (!m_act[c]) begin
        if (dir != 0) begin
          m_act[c] = 1; m_held[c] = 0; m_dir[c] = dir;
        end
      end else if (dir == 0) begin
        m_act[c] = 0; m_held[c] = 0; m_dir[c] = 0;
      end else if (dir != m_dir[c]) begin
        m_dir[c] = dir; m_held[c] = 0;
      end else if (tk) begin
        step = (m_held[c] >= AT) ? 3 : 1;
        m_y[c] = m_y[c] + dir * step;
        m_held[c]++;
      end
      if (m_y[c] < lo) m_y[c] = lo;
      if (m_y[c] > hi) m_y[c] = hi;
    end
    for (int b = 0; b < 4; b++) begin
      if (m_s2[b] != m_acc[b]) begin
        m_streak[b]++;
        if (m_streak[b] == DB) begin
          m_acc[b] = m_s2[b];
          m_streak[b] = 0;
        end
      end else begin
        m_streak[b] = 0;
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    model_update();
    #1;
    chk("p1_y", p1_y, m_y[0]);
    chk("p2_y", p2_y, m_y[1]);
    chk("p1_moving", p1_moving, m_act[0]);
    chk("p2_moving", p2_moving, m_act[1]);
  endtask

  initial begin
    int last, idx, gap, prev, d, found, n;
    int seq [6];
    int rmag [5];
    seq  = '{241, 242, 243, 244, 247, 250};
    rmag = '{1, 1, 1, 1, 3};
    model_reset();

    // Power-on reset
    repeat (3) step_cycle();
    chk("rst_p1_y", p1_y, 240);
    chk("rst_p2_y", p2_y, 240);
    chk("rst_p1_mv", p1_moving, 0);
    chk("rst_p2_mv", p2_moving, 0);
    rst = 1'b0;

    // Hold p1_down: four 1-pixel steps then 3-pixel steps, one per tick
    p1_down = 1'b1;
    last = 240; idx = 0; gap = 0;
    for (int i = 0; i < 200 && idx < 6; i++) begin
      step_cycle();
      gap++;
      if (p1_y != last) begin
        chk("down_seq", p1_y, seq[idx]);
        if (idx > 0) chk("down_gap", gap, TD);
        gap = 0;
        last = p1_y;
        idx++;
      end
    end
    chk("down_seq_len", idx, 6);
    chk("p2_still", p2_y, 240);
    p1_down = 1'b0;
    repeat (20) step_cycle();

    // Clamp at large bat, then small bat, then back to large
    p2_up = 1'b1;
    for (int i = 0; i < 1000 && p2_y != 59; i++) step_cycle();
    chk("p2_clamp_lg", p2_y, 59);
    repeat (16) step_cycle();
    chk("p2_hold_lg", p2_y, 59);
    bat_size = 1'b1;
    step_cycle();
    chk("p2_sz1_keep", p2_y, 59);
    for (int i = 0; i < 200 && p2_y != 49; i++) step_cycle();
    chk("p2_clamp_sm", p2_y, 49);
    repeat (16) step_cycle();
    chk("p2_hold_sm", p2_y, 49);
    bat_size = 1'b0;
    step_cycle();
    chk("p2_sz0_pull", p2_y, 59);
    p2_up = 1'b0;
    repeat (20) step_cycle();

    // Short glitch is rejected; both buttons means no movement
    last = p1_y;
    p1_up = 1'b1;
    repeat (3) step_cycle();
    p1_up = 1'b0;
    repeat (12) begin
      step_cycle();
      chk("glitch_mv", p1_moving, 0);
    end
    chk("glitch_y", p1_y, last);
    p1_up = 1'b1; p1_down = 1'b1;
    repeat (30) begin
      step_cycle();
      chk("both_mv", p1_moving, 0);
    end
    chk("both_y", p1_y, last);
    p1_up = 1'b0; p1_down = 1'b0;
    repeat (12) step_cycle();

    // Reach FAST going down, then reverse
    p1_down = 1'b1;
    prev = p1_y; found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      step_cycle();
      if (p1_y != prev) begin
        if (int'(p1_y) - prev == 3) found = 1;
        prev = p1_y;
      end
    end
    chk("fast_reached", found, 1);
    p1_down = 1'b0; p1_up = 1'b1;
    idx = 0; prev = p1_y;
    for (int i = 0; i < 300 && idx < 5; i++) begin
      step_cycle();
      if (p1_y != prev) begin
        d = int'(p1_y) - prev;
        prev = p1_y;
        if (d < 0) begin
          chk("rev_step", -d, rmag[idx]);
          idx++;
        end
      end
    end
    chk("rev_len", idx, 5);
    p1_up = 1'b0;
    repeat (20) step_cycle();

    // Recentre on a tick edge while p1 is moving
    p1_down = 1'b1;
    for (int i = 0; i < 2000 && p1_y < 300; i++) step_cycle();
    chk("reach300", (p1_y >= 300), 1);
    for (int i = 0; i < 2 * TD && (m_e % TD) != TD - 1; i++) step_cycle();
    center = 1'b1;
    step_cycle();
    center = 1'b0;
    chk("ctr_p1_y", p1_y, 240);
    chk("ctr_p2_y", p2_y, 240);
    chk("ctr_p1_mv", p1_moving, 0);
    chk("ctr_p2_mv", p2_moving, 0);
    p1_down = 1'b0;
    repeat (20) step_cycle();

    // Asynchronous reset mid-run, then prescaler phase restarts
    p1_down = 1'b1; p2_down = 1'b1;
    repeat (13) step_cycle();
    #2 rst = 1'b1;
    #1;
    chk("arst_p1_y", p1_y, 240);
    chk("arst_p2_y", p2_y, 240);
    chk("arst_p1_mv", p1_moving, 0);
    chk("arst_p2_mv", p2_moving, 0);
    step_cycle();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && p1_y == 240; i++) begin
      step_cycle();
      n++;
    end
    chk("arst_first_move", n, 8);
    p1_down = 1'b0; p2_down = 1'b0;
    repeat (20) step_cycle();

    // Random buttons, bat size and recentre pulses
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) {p1_up, p1_down} = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) {p2_up, p2_down} = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) bat_size = ~bat_size;
      center = ($urandom_range(0, 149) == 0);
      step_cycle();
    end
    center = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
